// File: rtl/fix_session_arbiter_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Interface : fix_session_arbiter_if
// Purpose   : Bundles the session-side and parser-side handshake signals of
//             fix_session_arbiter.
// Ports     : sess_valid_i/sess_data_i/sess_ready_o - N_SESS byte streams in
//             par_valid_o/par_data_o/par_ready_i     - merged stream to parser
//             par_ctrl_o, grant_o, busy_o, msg_done_o, err_ovf_o - status
//             Modport slave is the arbiter view; master is the environment.
// Revision  : 1.0 - initial release
//------------------------------------------------------------------------------
interface fix_session_arbiter_if #(
  parameter int N_SESS = 4
) ();
  localparam int c_gw = $clog2(N_SESS);

  logic [N_SESS-1:0]   sess_valid_i;
  logic [8*N_SESS-1:0] sess_data_i;
  logic [N_SESS-1:0]   sess_ready_o;
  logic                par_valid_o;
  logic [7:0]          par_data_o;
  logic                par_ready_i;
  logic                par_ctrl_o;
  logic [c_gw-1:0]     grant_o;
  logic                busy_o;
  logic                msg_done_o;
  logic                err_ovf_o;

  modport slave (
    input  sess_valid_i, sess_data_i, par_ready_i,
    output sess_ready_o, par_valid_o, par_data_o, par_ctrl_o,
           grant_o, busy_o, msg_done_o, err_ovf_o
  );

  modport master (
    output sess_valid_i, sess_data_i, par_ready_i,
    input  sess_ready_o, par_valid_o, par_data_o, par_ctrl_o,
           grant_o, busy_o, msg_done_o, err_ovf_o
  );
endinterface
`default_nettype wire

// File: rtl/fix_session_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : fix_session_arbiter
// Purpose  : Round-robin multiplexer of N_SESS FIX byte streams onto a single
//            parser. A whole message is forwarded from one session, prefixed
//            with an injected SOH, and ends on the SOH that follows the
//            "10=" checksum field. Messages reaching MAX_BYTES without an end
//            are aborted.
// Ports    : clk, rst_n (async, active-low)
//            bus (slave) - session inputs, parser output, grant and status
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module fix_session_arbiter #(
  parameter int N_SESS    = 4,
  parameter int MAX_BYTES = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fix_session_arbiter_if.slave bus
);
  localparam int              c_gw  = $clog2(N_SESS);
  localparam int              c_cw  = $clog2(MAX_BYTES + 1);
  localparam logic [c_cw-1:0] c_max = c_cw'(MAX_BYTES);
  localparam logic [7:0]      c_soh = 8'h01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INJ  = 2'd1,
    XFER = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [c_gw-1:0] grant_q, grant_d;
  logic [c_gw-1:0] last_grant_q, last_grant_d;
  logic [c_cw-1:0] byte_cnt_q, byte_cnt_d;
  // Trailer match progress: 0 none, 1 after SOH, 2 after "1", 3 after "10".
  logic [1:0]      match_q, match_d;
  logic            cks_seen_q, cks_seen_d;
  logic            par_ctrl_q, par_ctrl_d;
  logic            msg_done_q, msg_done_d;
  logic            err_ovf_q, err_ovf_d;

  logic [c_gw-1:0]   rr_sel;
  logic [c_gw-1:0]   rr_cand;
  logic              rr_found;
  int                rr_idx;
  logic              gnt_valid;
  logic [7:0]        gnt_byte;
  logic              xfer_fire;
  logic              end_hit;
  logic [c_cw-1:0]   cnt_inc;
  logic [N_SESS-1:0] ready_vec;
  logic              out_valid;
  logic [7:0]        out_data;

  assign gnt_valid = bus.sess_valid_i[grant_q];
  assign gnt_byte  = bus.sess_data_i[8*grant_q +: 8];
  assign xfer_fire = (state_q == XFER) && gnt_valid && bus.par_ready_i;
  assign cnt_inc   = (byte_cnt_q == c_max) ? byte_cnt_q : byte_cnt_q + 1'b1;

  // Round-robin search starting at the session after the last one served.
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = '0;
    rr_idx   = 0;
    rr_cand  = '0;
    for (int i = 1; i <= N_SESS; i++) begin
      rr_idx  = (int'(last_grant_q) + i) % N_SESS;
      rr_cand = c_gw'(rr_idx);
      if (!rr_found && bus.sess_valid_i[rr_cand]) begin
        rr_found = 1'b1;
        rr_sel   = rr_cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    byte_cnt_d   = byte_cnt_q;
    match_d      = match_q;
    cks_seen_d   = cks_seen_q;
    par_ctrl_d   = 1'b0;
    msg_done_d   = 1'b0;
    err_ovf_d    = 1'b0;
    end_hit      = 1'b0;
    case (state_q)
      IDLE: begin
        if (rr_found) begin
          grant_d    = rr_sel;
          par_ctrl_d = 1'b1;
          state_d    = INJ;
        end
      end
      INJ: begin
        if (bus.par_ready_i) state_d = XFER;
      end
      XFER: begin
        if (xfer_fire) begin
          byte_cnt_d = cnt_inc;
          // Every SOH restarts the trailer match; "10=" only counts when it
          // directly follows an SOH, so body text like "110=" is ignored.
          if (gnt_byte == c_soh) begin
            end_hit = cks_seen_q;
            match_d = 2'd1;
          end else begin
            case (match_q)
              2'd1:    match_d = (gnt_byte == 8'h31) ? 2'd2 : 2'd0;
              2'd2:    match_d = (gnt_byte == 8'h30) ? 2'd3 : 2'd0;
              2'd3: begin
                match_d = 2'd0;
                if (gnt_byte == 8'h3D) cks_seen_d = 1'b1;
              end
              default: match_d = 2'd0;
            endcase
          end
          // A normal end takes priority over an overlength on the same byte.
          if (end_hit) begin
            msg_done_d   = 1'b1;
            last_grant_d = grant_q;
            state_d      = GAP;
          end else if (cnt_inc == c_max) begin
            err_ovf_d    = 1'b1;
            last_grant_d = grant_q;
            state_d      = GAP;
          end
        end
      end
      GAP: begin
        byte_cnt_d = '0;
        cks_seen_d = 1'b0;
        match_d    = 2'd0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_vec = '0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    case (state_q)
      INJ: begin
        out_valid = 1'b1;
        out_data  = c_soh;
      end
      XFER: begin
        out_valid          = gnt_valid;
        out_data           = gnt_byte;
        ready_vec[grant_q] = bus.par_ready_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= c_gw'(N_SESS - 1);
      byte_cnt_q   <= '0;
      match_q      <= 2'd0;
      cks_seen_q   <= 1'b0;
      par_ctrl_q   <= 1'b0;
      msg_done_q   <= 1'b0;
      err_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      byte_cnt_q   <= byte_cnt_d;
      match_q      <= match_d;
      cks_seen_q   <= cks_seen_d;
      par_ctrl_q   <= par_ctrl_d;
      msg_done_q   <= msg_done_d;
      err_ovf_q    <= err_ovf_d;
    end
  end

  assign bus.sess_ready_o = ready_vec;
  assign bus.par_valid_o  = out_valid;
  assign bus.par_data_o   = out_data;
  assign bus.par_ctrl_o   = par_ctrl_q;
  assign bus.grant_o      = grant_q;
  assign bus.busy_o       = (state_q == INJ) || (state_q == XFER);
  assign bus.msg_done_o   = msg_done_q;
  assign bus.err_ovf_o    = err_ovf_q;
endmodule
`default_nettype wire

// File: doc/fix_session_arbiter.md
FIX_SESSION_ARBITER -- requirements
Module: fix_session_arbiter

Interface
REQ-001 SHALL have parameter N_SESS, default 4, number of FIX input sessions sharing one parser (2..8).
REQ-002 SHALL have parameter MAX_BYTES, default 1024, maximum byte count per message before abort.
REQ-003 SHALL have `clk  in  1`: the single clock; all state updates on its rising edge.
REQ-004 SHALL have `rst_n  in  1`: reset, asynchronous assert, active-low.
REQ-005 SHALL have `sess_valid_i  in  N_SESS`: per-session byte valid.
REQ-006 SHALL have `sess_data_i  in  8*N_SESS`: per-session byte; session k occupies bits [8k+7:8k].
REQ-007 SHALL have `sess_ready_o  out  N_SESS`: per-session byte accept.
REQ-008 SHALL have `par_valid_o  out  1`: byte valid toward the parser.
REQ-009 SHALL have `par_data_o  out  8`: byte toward the parser.
REQ-010 SHALL have `par_ready_i  in  1`: the parser accepts a byte.
REQ-011 SHALL have `par_ctrl_o  out  1`: one-cycle message-start strobe to the parser.
REQ-012 SHALL have `grant_o  out  clog2(N_SESS)`: the session currently owning the parser.
REQ-013 SHALL have `busy_o  out  1`: a message is in flight.
REQ-014 SHALL have `msg_done_o  out  1`: one-cycle pulse when a message completes normally.
REQ-015 SHALL have `err_ovf_o  out  1`: one-cycle pulse when a message is aborted for overlength.

Function
REQ-016 SHALL implement an FSM with states IDLE, INJ, XFER, GAP.
REQ-017 In IDLE with any sess_valid_i bit high, SHALL select a session by round-robin starting at (last_grant+1) mod N_SESS, register grant_o, pulse par_ctrl_o for 1 cycle, and go to INJ.
REQ-018 In INJ, SHALL drive par_valid_o=1 and par_data_o=8'h01 (leading SOH for parser sync); go to XFER on the cycle par_ready_i=1.
REQ-019 In XFER, SHALL drive par_valid_o=sess_valid_i[grant], par_data_o=the granted session's byte, sess_ready_o[grant]=par_ready_i, and all other sess_ready_o bits 0.
REQ-020 A byte transfers only when par_valid_o and par_ready_i are both 1; byte_cnt SHALL increment by 1 per transfer and saturate at MAX_BYTES.
REQ-021 SHALL track the checksum trailer: after a transferred 8'h01, match the next three transferred bytes to "1","0","=" (8'h31,8'h30,8'h3D) to set cks_seen; any mismatch SHALL clear the match sequence.
REQ-022 A transferred 8'h01 while cks_seen=1 SHALL end the message: msg_done_o pulses the next cycle, last_grant<=grant, and the FSM goes to GAP.
REQ-023 If byte_cnt reaches MAX_BYTES with no end detected, SHALL pulse err_ovf_o, set last_grant<=grant, and go to GAP; the remaining session bytes are not the block's responsibility.
REQ-024 End detection and overlength on the same transfer SHALL count as a normal end (msg_done_o only).
REQ-025 GAP SHALL last exactly 1 cycle with par_valid_o=0 and all sess_ready_o=0, clear byte_cnt and cks_seen, then return to IDLE.
REQ-026 Outside XFER, all sess_ready_o SHALL be 0; in IDLE and GAP, par_valid_o SHALL be 0.
REQ-027 busy_o SHALL be 1 in INJ and XFER, and 0 otherwise.
REQ-028 The grant SHALL never change mid-message; new requests SHALL wait until IDLE.
REQ-029 A session whose sess_valid_i drops mid-message SHALL retain the grant, with no timeout.

Reset
REQ-030 On rst_n=0, SHALL immediately set: state=IDLE; grant_o=0; last_grant=N_SESS-1; byte_cnt=0; cks_seen=0; all outputs 0.
REQ-031 Reset mid-message SHALL abandon the message with no msg_done_o and no err_ovf_o pulse.
REQ-032 The first arbitration after reset SHALL favour session 0.

Verification
REQ-033 Single session 2 sends "8=FIX.4.2^9=5^35=0^10=161^", par_ready_i=1 -> par_ctrl_o pulse, then 8'h01, then all bytes in order; msg_done_o one cycle after the final ^; grant_o=2.
REQ-034 Sessions 0 and 1 both request after reset -> 0 served first, then 1 after GAP; a later 0+1 request serves 1's neighbour 0 only after 1 completes, i.e. strict rotation.
REQ-035 par_ready_i toggling 1,0,1,0 during XFER -> no byte lost or duplicated; sess_ready_o[grant] mirrors par_ready_i.
REQ-036 With MAX_BYTES=16, a 20-byte message lacking "10=" -> err_ovf_o pulse after byte 16, GAP, then the next requester is granted.
REQ-037 Body containing "110=5^" -> not treated as the trailer (match only directly after SOH); the message continues.
REQ-038 rst_n asserted during XFER at byte 7 -> outputs 0 immediately; no pulses; the next grant goes to session 0.
